// File: rtl/cbs_window_sched.sv
// -----------------------------------------------------------------------------
// cbs_window_sched
// Read-address sequencer for one conv-BN-SiLU layer pass. Every KSIZE x KSIZE
// window of an IMG_W x IMG_H feature map (stride STRIDE, no padding) is
// visited. The sequencer issues one linear address per kernel tap, with
// valid/ready flow control. Loop order from innermost to outermost is kx, ky,
// ox, oy.
//
// Ports:
//   clk        in   clock
//   reset      in   asynchronous active-high reset
//   start      in   one-cycle pulse; starts a frame pass when idle
//   abort      in   cancels a pass in progress (no done pulse)
//   addr_ready in   consumer accepts the current beat
//   addr_valid out  addr/tap_idx/win_last/frame_last are valid
//   addr       out  linear read address
//   tap_idx    out  ky*KSIZE+kx
//   win_last   out  last tap of the current window
//   frame_last out  last tap of the last window
//   out_row    out  output row oy of the current window
//   out_col    out  output column ox of the current window
//   busy       out  pass in progress
//   done       out  one-cycle pulse after the final beat is accepted
// -----------------------------------------------------------------------------
module cbs_window_sched #(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 640,
  parameter int KSIZE     = 3,
  parameter int STRIDE    = 1,
  parameter int ADDR_W    = 25,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              addr_ready,
  output logic              addr_valid,
  output logic [ADDR_W-1:0] addr,
  output logic [5:0]        tap_idx,
  output logic              win_last,
  output logic              frame_last,
  output logic [15:0]       out_row,
  output logic [15:0]       out_col,
  output logic              busy,
  output logic              done
);

  localparam int OUT_W = (IMG_W - KSIZE) / STRIDE + 1;
  localparam int OUT_H = (IMG_H - KSIZE) / STRIDE + 1;

  localparam logic [2:0]        K_LAST     = 3'(KSIZE - 1);
  localparam logic [5:0]        TAP_LAST   = 6'(KSIZE * KSIZE - 1);
  localparam logic [15:0]       OX_LAST    = 16'(OUT_W - 1);
  localparam logic [15:0]       OY_LAST    = 16'(OUT_H - 1);
  localparam logic [ADDR_W-1:0] A_BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] A_IMG_W    = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] A_STRIDE   = ADDR_W'(STRIDE);
  // Elaboration-time constant; the datapath only ever adds it.
  localparam logic [ADDR_W-1:0] A_ROW_STEP = ADDR_W'(STRIDE * IMG_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [2:0]        r_kx;
  logic [2:0]        r_ky;
  logic [5:0]        r_tap;
  logic [15:0]       r_ox;
  logic [15:0]       r_oy;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_row_base;  // top-left of window ox=0 in this output row
  logic [ADDR_W-1:0] r_win_base;  // top-left of the current window
  logic [ADDR_W-1:0] r_tap_row;   // first tap of the current kernel row

  logic              w_run;
  logic              w_hs;
  logic              w_win_last;
  logic              w_frame_last;
  logic [ADDR_W-1:0] w_tap_row_next;
  logic [ADDR_W-1:0] w_win_next;
  logic [ADDR_W-1:0] w_row_next;

  assign w_run          = (r_state == S_RUN);
  assign w_hs           = w_run & addr_ready;
  // Gated by RUN so the markers stay low outside a pass, including KSIZE=1.
  assign w_win_last     = w_run & (r_tap == TAP_LAST);
  assign w_frame_last   = w_win_last & (r_ox == OX_LAST) & (r_oy == OY_LAST);
  assign w_tap_row_next = r_tap_row + A_IMG_W;
  assign w_win_next     = r_win_base + A_STRIDE;
  assign w_row_next     = r_row_base + A_ROW_STEP;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. Abort takes priority over a same-cycle handshake.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_next = S_RUN;
      S_RUN: begin
        if (abort) begin
          w_state_next = S_IDLE;
        end else if (w_hs && w_frame_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Index counters and address pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_kx       <= '0;
      r_ky       <= '0;
      r_tap      <= '0;
      r_ox       <= '0;
      r_oy       <= '0;
      r_addr     <= A_BASE;
      r_row_base <= A_BASE;
      r_win_base <= A_BASE;
      r_tap_row  <= A_BASE;
    end else if (r_state == S_IDLE && start) begin
      r_kx       <= '0;
      r_ky       <= '0;
      r_tap      <= '0;
      r_ox       <= '0;
      r_oy       <= '0;
      r_addr     <= A_BASE;
      r_row_base <= A_BASE;
      r_win_base <= A_BASE;
      r_tap_row  <= A_BASE;
    end else if (w_hs && !abort && !w_frame_last) begin
      if (r_kx != K_LAST) begin
        // Next tap along the current kernel row.
        r_kx   <= r_kx + 3'd1;
        r_tap  <= r_tap + 6'd1;
        r_addr <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else if (r_ky != K_LAST) begin
        // Drop to the next kernel row of the same window.
        r_kx      <= '0;
        r_ky      <= r_ky + 3'd1;
        r_tap     <= r_tap + 6'd1;
        r_tap_row <= w_tap_row_next;
        r_addr    <= w_tap_row_next;
      end else begin
        r_kx  <= '0;
        r_ky  <= '0;
        r_tap <= '0;
        if (r_ox != OX_LAST) begin
          // Slide the window right by STRIDE.
          r_ox       <= r_ox + 16'd1;
          r_win_base <= w_win_next;
          r_tap_row  <= w_win_next;
          r_addr     <= w_win_next;
        end else begin
          // Wrap to the first window of the next output row.
          r_ox       <= '0;
          r_oy       <= r_oy + 16'd1;
          r_row_base <= w_row_next;
          r_win_base <= w_row_next;
          r_tap_row  <= w_row_next;
          r_addr     <= w_row_next;
        end
      end
    end
  end

  assign addr_valid = w_run;
  assign busy       = w_run;
  assign done       = (r_state == S_DONE);
  assign addr       = r_addr;
  assign tap_idx    = r_tap;
  assign win_last   = w_win_last;
  assign frame_last = w_frame_last;
  assign out_row    = r_oy;
  assign out_col    = r_ox;

endmodule

// File: tb/tb_cbs_window_sched.sv
// -----------------------------------------------------------------------------
// tb_cbs_window_sched
// Three scheduler instances with different geometries are checked every cycle
// against a beat-index model. The model derives every output field from the
// beat number with plain division and multiplication. Directed literal checks
// pin the model to hand-computed address sequences.
// -----------------------------------------------------------------------------
module tb_cbs_window_sched;

  logic clk;
  logic reset;

  logic        start_i [3];
  logic        abort_i [3];
  logic        ready_i [3];
  logic        valid_o [3];
  logic [15:0] addr_o  [3];
  logic [5:0]  tap_o   [3];
  logic        wl_o    [3];
  logic        fl_o    [3];
  logic [15:0] row_o   [3];
  logic [15:0] col_o   [3];
  logic        busy_o  [3];
  logic        done_o  [3];

  // Geometry per instance: 0 = 5x4 k3 s1, 1 = 5x5 k3 s2, 2 = 4x2 k1 s1 base 100
  int cW[3]    = '{5, 5, 4};
  int cH[3]    = '{4, 5, 2};
  int cK[3]    = '{3, 3, 1};
  int cS[3]    = '{1, 2, 1};
  int cBASE[3] = '{0, 0, 100};

  // Model state
  bit run[3];
  bit dn[3];
  int beat[3];
  int done_cnt[3];
  int wl_cnt2;
  int cap0[$];
  int cap1[$];
  int cap2[$];

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cbs_window_sched #(.IMG_W(5), .IMG_H(4), .KSIZE(3), .STRIDE(1), .ADDR_W(16), .BASE_ADDR(0)) u_a (
    .clk(clk), .reset(reset), .start(start_i[0]), .abort(abort_i[0]), .addr_ready(ready_i[0]),
    .addr_valid(valid_o[0]), .addr(addr_o[0]), .tap_idx(tap_o[0]), .win_last(wl_o[0]),
    .frame_last(fl_o[0]), .out_row(row_o[0]), .out_col(col_o[0]), .busy(busy_o[0]), .done(done_o[0]));

  cbs_window_sched #(.IMG_W(5), .IMG_H(5), .KSIZE(3), .STRIDE(2), .ADDR_W(16), .BASE_ADDR(0)) u_b (
    .clk(clk), .reset(reset), .start(start_i[1]), .abort(abort_i[1]), .addr_ready(ready_i[1]),
    .addr_valid(valid_o[1]), .addr(addr_o[1]), .tap_idx(tap_o[1]), .win_last(wl_o[1]),
    .frame_last(fl_o[1]), .out_row(row_o[1]), .out_col(col_o[1]), .busy(busy_o[1]), .done(done_o[1]));

  cbs_window_sched #(.IMG_W(4), .IMG_H(2), .KSIZE(1), .STRIDE(1), .ADDR_W(16), .BASE_ADDR(100)) u_c (
    .clk(clk), .reset(reset), .start(start_i[2]), .abort(abort_i[2]), .addr_ready(ready_i[2]),
    .addr_valid(valid_o[2]), .addr(addr_o[2]), .tap_idx(tap_o[2]), .win_last(wl_o[2]),
    .frame_last(fl_o[2]), .out_row(row_o[2]), .out_col(col_o[2]), .busy(busy_o[2]), .done(done_o[2]));

  task automatic chk(input string nm, input int i, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t got=%0d want=%0d", nm, i, $time, act, exp);
    end
  endtask

  function automatic int last_beat(input int i);
    int ow, oh;
    ow = (cW[i] - cK[i]) / cS[i] + 1;
    oh = (cH[i] - cK[i]) / cS[i] + 1;
    return ow * oh * cK[i] * cK[i] - 1;
  endfunction

  // Expected fields of beat b, straight from the window/tap decomposition.
  task automatic model_beat(input int i, input int b, output int ea, output int et,
                            output int ewl, output int efl, output int er, output int ec);
    int taps, win, t, ow, ox, oy, kx, ky;
    taps = cK[i] * cK[i];
    ow   = (cW[i] - cK[i]) / cS[i] + 1;
    win  = b / taps;
    t    = b % taps;
    ox   = win % ow;
    oy   = win / ow;
    ky   = t / cK[i];
    kx   = t % cK[i];
    ea   = cBASE[i] + (oy * cS[i] + ky) * cW[i] + ox * cS[i] + kx;
    et   = t;
    ewl  = (t == taps - 1) ? 1 : 0;
    efl  = (b == last_beat(i)) ? 1 : 0;
    er   = oy;
    ec   = ox;
  endtask

  // Per-cycle comparison of all instances; runs on the falling edge.
  task automatic compare_all();
    int ea, et, ewl, efl, er, ec;
    bit nd;
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        chk("rst_valid", i, int'(valid_o[i]), 0);
        chk("rst_busy", i, int'(busy_o[i]), 0);
        chk("rst_done", i, int'(done_o[i]), 0);
        chk("rst_addr", i, int'(addr_o[i]), cBASE[i]);
        chk("rst_tap", i, int'(tap_o[i]), 0);
        chk("rst_wl", i, int'(wl_o[i]), 0);
        chk("rst_fl", i, int'(fl_o[i]), 0);
        chk("rst_row", i, int'(row_o[i]), 0);
        chk("rst_col", i, int'(col_o[i]), 0);
        run[i] = 1'b0;
        dn[i]  = 1'b0;
        continue;
      end
      chk("valid", i, int'(valid_o[i]), int'(run[i]));
      chk("busy", i, int'(busy_o[i]), int'(run[i]));
      chk("done", i, int'(done_o[i]), int'(dn[i]));
      if (done_o[i]) done_cnt[i]++;
      if (run[i]) begin
        model_beat(i, beat[i], ea, et, ewl, efl, er, ec);
        chk("addr", i, int'(addr_o[i]), ea);
        chk("tap_idx", i, int'(tap_o[i]), et);
        chk("win_last", i, int'(wl_o[i]), ewl);
        chk("frame_last", i, int'(fl_o[i]), efl);
        chk("out_row", i, int'(row_o[i]), er);
        chk("out_col", i, int'(col_o[i]), ec);
        if (ready_i[i] && !abort_i[i]) begin
          if (i == 0) cap0.push_back(int'(addr_o[i]));
          if (i == 1) cap1.push_back(int'(addr_o[i]));
          if (i == 2) begin
            cap2.push_back(int'(addr_o[i]));
            wl_cnt2 += int'(wl_o[i]);
          end
        end
      end
      // Advance the model to the state expected after the coming edge.
      nd = 1'b0;
      if (run[i]) begin
        if (abort_i[i]) begin
          run[i] = 1'b0;
        end else if (ready_i[i]) begin
          if (beat[i] == last_beat(i)) begin
            run[i] = 1'b0;
            nd     = 1'b1;
          end else begin
            beat[i]++;
          end
        end
      end else if (!dn[i] && start_i[i]) begin
        run[i]  = 1'b1;
        beat[i] = 0;
      end
      dn[i] = nd;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int i);
    start_i[i] = 1'b1;
    tick();
    start_i[i] = 1'b0;
  endtask

  // Runs instance i to the end of its pass; alt toggles ready every cycle.
  task automatic run_to_idle(input int i, input bit alt);
    int n = 0;
    while ((run[i] || dn[i]) && n < 500) begin
      if (alt) ready_i[i] = n[0];
      tick();
      n++;
    end
    ready_i[i] = 1'b1;
    if (n >= 500) begin
      chk("timeout_idle", i, n, 0);
    end
  endtask

  task automatic wait_beat(input int i, input int b);
    int n = 0;
    while (!(run[i] && beat[i] == b) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) begin
      chk("timeout_beat", i, n, 0);
    end
  endtask

  initial begin
    int exp_first[9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    int exp_last[9]  = '{7, 8, 9, 12, 13, 14, 17, 18, 19};
    int exp_wb[4]    = '{0, 2, 10, 12};
    int d0;

    checks  = 0;
    errors  = 0;
    wl_cnt2 = 0;
    reset   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_i[i]  = 1'b0;
      abort_i[i]  = 1'b0;
      ready_i[i]  = 1'b1;
      run[i]      = 1'b0;
      dn[i]       = 1'b0;
      beat[i]     = 0;
      done_cnt[i] = 0;
    end
    repeat (3) tick();
    reset = 1'b0;
    chk("lit_rst_base", 2, int'(addr_o[2]), 100);
    tick();

    // Full pass, ready always high
    $display("TXN A1 full pass 5x4 k3 s1");
    pulse_start(0);
    run_to_idle(0, 1'b0);
    tick();
    chk("lit_a1_beats", 0, cap0.size(), 54);
    if (cap0.size() == 54) begin
      for (int j = 0; j < 9; j++) chk("lit_a1_first", j, cap0[j], exp_first[j]);
      chk("lit_a1_win2", 0, cap0[9], 1);
      for (int j = 0; j < 9; j++) chk("lit_a1_last", j, cap0[45 + j], exp_last[j]);
    end
    chk("lit_a1_done", 0, done_cnt[0], 1);

    // Stall on the fourth beat, plus an ignored start while running
    $display("TXN A2 stall at addr 5");
    cap0.delete();
    pulse_start(0);
    wait_beat(0, 3);
    ready_i[0] = 1'b0;
    start_i[0] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      start_i[0] = 1'b0;
      chk("lit_a2_hold_addr", j, int'(addr_o[0]), 5);
      chk("lit_a2_hold_tap", j, int'(tap_o[0]), 3);
    end
    ready_i[0] = 1'b1;
    run_to_idle(0, 1'b0);
    tick();
    chk("lit_a2_beats", 0, cap0.size(), 54);
    chk("lit_a2_done", 0, done_cnt[0], 2);

    // Abort at beat 20 with ready high
    $display("TXN A3 abort at beat 20");
    pulse_start(0);
    wait_beat(0, 20);
    abort_i[0] = 1'b1;
    tick();
    abort_i[0] = 1'b0;
    chk("lit_a3_valid", 0, int'(valid_o[0]), 0);
    d0 = done_cnt[0];
    repeat (3) tick();
    chk("lit_a3_nodone", 0, done_cnt[0], d0);
    pulse_start(0);
    chk("lit_a3_restart_addr", 0, int'(addr_o[0]), 0);
    chk("lit_a3_restart_tap", 0, int'(tap_o[0]), 0);

    // Asynchronous reset in the middle of a window
    $display("TXN A4 async reset mid-window");
    wait_beat(0, 10);
    #2;
    reset = 1'b1;
    #1;
    chk("lit_a4_valid", 0, int'(valid_o[0]), 0);
    chk("lit_a4_addr", 0, int'(addr_o[0]), 0);
    chk("lit_a4_tap", 0, int'(tap_o[0]), 0);
    chk("lit_a4_busy", 0, int'(busy_o[0]), 0);
    tick();
    reset = 1'b0;
    tick();

    // Stride 2
    $display("TXN B stride 2 on 5x5");
    pulse_start(1);
    run_to_idle(1, 1'b0);
    tick();
    chk("lit_b_beats", 1, cap1.size(), 36);
    if (cap1.size() == 36) begin
      for (int j = 0; j < 4; j++) chk("lit_b_winbase", j, cap1[9 * j], exp_wb[j]);
      chk("lit_b_final", 1, cap1[35], 24);
    end
    chk("lit_b_done", 1, done_cnt[1], 1);

    // 1x1 kernel with base offset and ready toggling
    $display("TXN C k1 base 100");
    pulse_start(2);
    run_to_idle(2, 1'b1);
    tick();
    chk("lit_c_beats", 2, cap2.size(), 8);
    if (cap2.size() == 8) begin
      for (int j = 0; j < 8; j++) chk("lit_c_addr", j, cap2[j], 100 + j);
    end
    chk("lit_c_winlast", 2, wl_cnt2, 8);
    chk("lit_c_done", 2, done_cnt[2], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
